// File: rtl/sram_device_model_if.sv
// -----------------------------------------------------------------------------
// sram_device_model_if
// Pin-level bundle of the external 16-bit asynchronous SRAM.
//   SRAM_DQ    : bidirectional data bus (net, resolved between both ends)
//   SRAM_ADDR  : word address from the controller
//   SRAM_UB_N  : upper byte [15:8] enable, active-low
//   SRAM_LB_N  : lower byte [7:0] enable, active-low
//   SRAM_WE_N  : write enable, active-low
//   SRAM_CE_N  : chip enable, active-low
//   SRAM_OE_N  : output enable, active-low
// Modports: master = controller end, slave = device end.
// -----------------------------------------------------------------------------
interface sram_device_model_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16
);
    wire  [DATA_W-1:0] SRAM_DQ;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_UB_N;
    logic              SRAM_LB_N;
    logic              SRAM_WE_N;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;

    modport master (
        inout  SRAM_DQ,
        output SRAM_ADDR,
        output SRAM_UB_N,
        output SRAM_LB_N,
        output SRAM_WE_N,
        output SRAM_CE_N,
        output SRAM_OE_N
    );

    modport slave (
        inout  SRAM_DQ,
        input  SRAM_ADDR,
        input  SRAM_UB_N,
        input  SRAM_LB_N,
        input  SRAM_WE_N,
        input  SRAM_CE_N,
        input  SRAM_OE_N
    );
endinterface

// File: rtl/sram_device_model.sv
// -----------------------------------------------------------------------------
// sram_device_model
// Cycle-based device-side model of a 16-bit asynchronous SRAM. Stores words with
// byte-lane masking, withholds valid read data until the address has been stable
// for READ_LAT clock edges, and counts committed writes and completed reads.
//
// Ports:
//   clk        : clock, all sampling on posedge
//   rst        : asynchronous active-high reset (counters, stability state only)
//   sram       : SRAM pin bundle, slave modport
//   rd_count   : completed read accesses, saturating
//   wr_count   : write strobes committed, saturating
//   contention : sticky bus-contention flag
//
// Optional feature macro: SRAM_CONTENTION_CHECK_EN
//   defined   - flags any mismatch between the driven value and the resolved bus
//   undefined - contention is tied low, no checking logic
//
// DATA_W must be 16: the two byte lanes are hard-wired to [15:8] and [7:0].
// -----------------------------------------------------------------------------
module sram_device_model #(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_WORDS = 262144,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    sram_device_model_if.slave sram,
    output logic [CNT_W-1:0]   rd_count,
    output logic [CNT_W-1:0]   wr_count,
    output logic               contention
);
    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [2:0]  LAT   = 3'(READ_LAT);

    logic [DATA_W-1:0] r_mem [MEM_WORDS];
    logic [ADDR_W-1:0] r_prev_addr;
    logic [2:0]        r_stab;
    logic [CNT_W-1:0]  r_rd_count;
    logic [CNT_W-1:0]  r_wr_count;

    logic [IDX_W-1:0]  w_idx;
    logic              w_addr_same;
    logic              w_write;
    logic              w_wr_any;
    logic              w_drive;
    logic              w_stab_clr;
    logic [2:0]        w_stab_eff;
    logic [2:0]        w_stab_d;
    logic              w_valid;
    logic              w_rd_inc;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_dq_out;
    logic              w_lo_en;
    logic              w_hi_en;

    // Upper address bits are ignored, so the array aliases across the address space.
    assign w_idx = sram.SRAM_ADDR[IDX_W-1:0];

    always_comb begin
        w_addr_same = (sram.SRAM_ADDR == r_prev_addr);
        w_write     = !sram.SRAM_CE_N && !sram.SRAM_WE_N;
        w_wr_any    = w_write && (!sram.SRAM_UB_N || !sram.SRAM_LB_N);
        w_drive     = !sram.SRAM_CE_N && !sram.SRAM_OE_N && sram.SRAM_WE_N;
        w_stab_clr  = !w_addr_same || !sram.SRAM_WE_N || sram.SRAM_CE_N;

        // The current address is compared against the registered one, so the cycle
        // in which the address moves already sees a stability of zero.
        w_stab_eff  = w_stab_clr ? 3'd0 : r_stab;
        w_valid     = (w_stab_eff >= LAT);

        w_stab_d    = 3'd0;
        if (!w_stab_clr) begin
            w_stab_d = (r_stab >= LAT) ? LAT : r_stab + 3'd1;
        end

        // One count per stable address window: the edge that reaches READ_LAT, or
        // for a zero-latency part every address change while driving.
        if (READ_LAT == 0) begin
            w_rd_inc = w_drive && !w_addr_same;
        end else begin
            w_rd_inc = w_drive && !w_stab_clr && (r_stab == LAT - 3'd1);
        end

        w_rd_word = r_mem[w_idx];
        w_dq_out  = w_valid ? w_rd_word : {DATA_W{1'bx}};

        // Before the access time the whole bus carries X; afterwards only enabled lanes drive.
        w_lo_en   = w_drive && (!w_valid || !sram.SRAM_LB_N);
        w_hi_en   = w_drive && (!w_valid || !sram.SRAM_UB_N);
    end

    assign sram.SRAM_DQ[7:0]  = w_lo_en ? w_dq_out[7:0]  : 8'hzz;
    assign sram.SRAM_DQ[15:8] = w_hi_en ? w_dq_out[15:8] : 8'hzz;

    // Storage is never reset; a strobe coinciding with reset is dropped so that
    // committed words survive a reset in the middle of a burst.
    always_ff @(posedge clk) begin
        if (!rst && w_write) begin
            if (!sram.SRAM_LB_N) begin
                r_mem[w_idx][7:0] <= sram.SRAM_DQ[7:0];
            end
            if (!sram.SRAM_UB_N) begin
                r_mem[w_idx][15:8] <= sram.SRAM_DQ[15:8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_addr <= '0;
            r_stab      <= 3'd0;
            r_rd_count  <= '0;
            r_wr_count  <= '0;
        end else begin
            r_prev_addr <= sram.SRAM_ADDR;
            r_stab      <= w_stab_d;
            if (w_rd_inc && (r_rd_count != {CNT_W{1'b1}})) begin
                r_rd_count <= r_rd_count + CNT_W'(1);
            end
            if (w_wr_any && (r_wr_count != {CNT_W{1'b1}})) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;

`ifdef SRAM_CONTENTION_CHECK_EN
    logic r_contention;
    logic w_conflict;

    // Any driven bit whose resolved value differs (X or an opposing driver) is a clash.
    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (((i < 8) ? w_lo_en : w_hi_en) && (sram.SRAM_DQ[i] !== w_rd_word[i])) begin
                w_conflict = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_contention <= 1'b0;
        end else if (w_drive && w_valid && w_conflict) begin
            r_contention <= 1'b1;
            $display("%t sram_device_model: bus contention at address %h", $time,
                     sram.SRAM_ADDR);
        end
    end

    assign contention = r_contention;
`else
    assign contention = 1'b0;
`endif

endmodule

// File: tb/tb_sram_device_model.sv
// -----------------------------------------------------------------------------
// tb_sram_device_model
// Directed bench for sram_device_model. Instance dut uses READ_LAT=1 and a
// 1024-word array (aliasing); instance dut3 uses READ_LAT=3 with 2-bit counters.
// -----------------------------------------------------------------------------
module tb_sram_device_model;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sram_device_model_if #(.ADDR_W(18), .DATA_W(16)) bus ();
    sram_device_model_if #(.ADDR_W(18), .DATA_W(16)) bus3 ();

    logic [15:0] tb_dq  = 16'h0000;
    logic [15:0] tb_dq3 = 16'h0000;
    logic        tb_en  = 1'b0;
    logic        tb_en3 = 1'b0;

    assign bus.SRAM_DQ  = tb_en  ? tb_dq  : 16'hzzzz;
    assign bus3.SRAM_DQ = tb_en3 ? tb_dq3 : 16'hzzzz;

    wire [15:0] rd_count;
    wire [15:0] wr_count;
    wire        contention;
    wire [1:0]  rd_count3;
    wire [1:0]  wr_count3;
    wire        contention3;

    sram_device_model #(
        .ADDR_W(18), .DATA_W(16), .MEM_WORDS(1024), .READ_LAT(1), .CNT_W(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sram       (bus),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .contention (contention)
    );

    sram_device_model #(
        .ADDR_W(18), .DATA_W(16), .MEM_WORDS(1024), .READ_LAT(3), .CNT_W(2)
    ) dut3 (
        .clk        (clk),
        .rst        (rst),
        .sram       (bus3),
        .rd_count   (rd_count3),
        .wr_count   (wr_count3),
        .contention (contention3)
    );

    always #5 clk = ~clk;

`ifdef SRAM_CONTENTION_CHECK_EN
    localparam logic EXP_CONT = 1'b1;
`else
    localparam logic EXP_CONT = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.SRAM_ADDR = '0;
        bus.SRAM_CE_N = 1'b1;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_OE_N = 1'b1;
        bus.SRAM_UB_N = 1'b1;
        bus.SRAM_LB_N = 1'b1;
        tb_en         = 1'b0;
    endtask

    // One write strobe across a single posedge; leaves the chip selected, WE/OE high.
    task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic ub_n,
                      input logic lb_n);
        bus.SRAM_ADDR = a;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b0;
        bus.SRAM_OE_N = 1'b1;
        bus.SRAM_UB_N = ub_n;
        bus.SRAM_LB_N = lb_n;
        tb_dq         = d;
        tb_en         = 1'b1;
        tick();
        bus.SRAM_WE_N = 1'b1;
        tb_en         = 1'b0;
    endtask

    task automatic rd_setup(input logic [17:0] a);
        bus.SRAM_ADDR = a;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_OE_N = 1'b0;
        bus.SRAM_UB_N = 1'b0;
        bus.SRAM_LB_N = 1'b0;
        tb_en         = 1'b0;
        #1;
    endtask

    initial begin
        idle();
        bus3.SRAM_ADDR = '0;
        bus3.SRAM_CE_N = 1'b1;
        bus3.SRAM_WE_N = 1'b1;
        bus3.SRAM_OE_N = 1'b1;
        bus3.SRAM_UB_N = 1'b1;
        bus3.SRAM_LB_N = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_contention", 32'(contention), 32'd0);
        chk("rst_dq_released", 32'({dut.w_hi_en, dut.w_lo_en}), 32'd0);
        rst = 1'b0;
        tick();

        // T1: single write then read at READ_LAT=1
        wr(18'd5, 16'h1234, 1'b0, 1'b0);
        chk("t1_wr_count", 32'(wr_count), 32'd1);
        bus.SRAM_OE_N = 1'b0;
        #1;
        chk("t1_first_cycle_invalid", 32'(dut.w_valid), 32'd0);
        chk("t1_first_cycle_driving", 32'({dut.w_hi_en, dut.w_lo_en}), 32'h3);
        chk("t1_rd_count_before", 32'(rd_count), 32'd0);
        tick();
        chk("t1_read_data", 32'(bus.SRAM_DQ), 32'h1234);
        chk("t1_rd_count", 32'(rd_count), 32'd1);
        tick();
        chk("t1_rd_count_held", 32'(rd_count), 32'd1);

        // T2: byte lanes
        wr(18'd7, 16'hAAAA, 1'b0, 1'b0);
        wr(18'd7, 16'h55CC, 1'b1, 1'b0);
        chk("t2_wr_count_lane", 32'(wr_count), 32'd3);
        wr(18'd7, 16'h0000, 1'b1, 1'b1);
        chk("t2_wr_count_no_lane", 32'(wr_count), 32'd3);
        rd_setup(18'd7);
        tick();
        chk("t2_read_data", 32'(bus.SRAM_DQ), 32'hAACC);
        chk("t2_rd_count", 32'(rd_count), 32'd2);
        bus.SRAM_UB_N = 1'b1;
        #1;
        chk("t2_low_lane_data", 32'(bus.SRAM_DQ[7:0]), 32'hCC);
        chk("t2_lane_enables", 32'({dut.w_hi_en, dut.w_lo_en}), 32'h1);
        bus.SRAM_UB_N = 1'b0;

        // T4: aliasing, address 1024 maps to word 0
        wr(18'd1024, 16'hBEEF, 1'b0, 1'b0);
        chk("t4_wr_count", 32'(wr_count), 32'd4);
        rd_setup(18'd0);
        chk("t4_addr_change_invalid", 32'(dut.w_valid), 32'd0);
        tick();
        chk("t4_still_invalid", 32'(dut.w_valid), 32'd0);
        chk("t4_rd_count_before", 32'(rd_count), 32'd2);
        tick();
        chk("t4_alias_data", 32'(bus.SRAM_DQ), 32'hBEEF);
        chk("t4_rd_count", 32'(rd_count), 32'd3);

        // T6: opposing drive during a valid read
        tb_dq = 16'h0000;
        tb_en = 1'b1;
        tick();
        tb_en = 1'b0;
        chk("t6_contention_set", 32'(contention), 32'(EXP_CONT));
        tick();
        chk("t6_contention_sticky", 32'(contention), 32'(EXP_CONT));
        idle();

        // T3 on dut3: WE held low over 4 edges gives 4 writes, counter saturates at 3
        bus3.SRAM_ADDR = 18'd3;
        bus3.SRAM_CE_N = 1'b0;
        bus3.SRAM_WE_N = 1'b0;
        bus3.SRAM_UB_N = 1'b0;
        bus3.SRAM_LB_N = 1'b0;
        tb_dq3         = 16'h00A5;
        tb_en3         = 1'b1;
        tick();
        tick();
        chk("t3_wr_count_two_edges", 32'(wr_count3), 32'd2);
        tick();
        tick();
        chk("t3_wr_count_saturated", 32'(wr_count3), 32'd3);
        bus3.SRAM_WE_N = 1'b1;
        bus3.SRAM_OE_N = 1'b0;
        tb_en3         = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus3.SRAM_ADDR = k[0] ? 18'd3 : 18'd4;
            tick();
            chk("t3_toggle_invalid_a", 32'(dut3.w_valid), 32'd0);
            tick();
            chk("t3_toggle_invalid_b", 32'(dut3.w_valid), 32'd0);
        end
        chk("t3_toggle_rd_count", 32'(rd_count3), 32'd0);
        bus3.SRAM_ADDR = 18'd3;
        tick();
        tick();
        tick();
        chk("t3_hold3_invalid", 32'(dut3.w_valid), 32'd0);
        chk("t3_hold3_rd_count", 32'(rd_count3), 32'd0);
        tick();
        chk("t3_hold4_data", 32'(bus3.SRAM_DQ), 32'h00A5);
        chk("t3_hold4_rd_count", 32'(rd_count3), 32'd1);
        bus3.SRAM_CE_N = 1'b1;
        bus3.SRAM_OE_N = 1'b1;

        // T5: reset between the two words of a burst
        bus.SRAM_ADDR = 18'd10;
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b0;
        bus.SRAM_OE_N = 1'b1;
        bus.SRAM_UB_N = 1'b0;
        bus.SRAM_LB_N = 1'b0;
        tb_dq         = 16'h1111;
        tb_en         = 1'b1;
        tick();
        chk("t5_first_word_count", 32'(wr_count), 32'd5);
        bus.SRAM_ADDR = 18'd11;
        tb_dq         = 16'h2222;
        rst           = 1'b1;
        #1;
        chk("t5_rst_wr_count", 32'(wr_count), 32'd0);
        chk("t5_rst_rd_count", 32'(rd_count), 32'd0);
        chk("t5_rst_contention", 32'(contention), 32'd0);
        idle();
        tick();
        chk("t5_dq_released", 32'({dut.w_hi_en, dut.w_lo_en}), 32'd0);
        rst = 1'b0;
        rd_setup(18'd10);
        tick();
        tick();
        chk("t5_first_word_kept", 32'(bus.SRAM_DQ), 32'h1111);
        chk("t5_rd_count_after", 32'(rd_count), 32'd1);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
